// File: rtl/conv_pkg.sv
// conv_pkg: shared width, FSM state encoding and saturation limit for the conv pipeline.
package conv_pkg;
   localparam int WIDTH = 8;
   typedef enum logic [2:0] {IDLE, REQ, WAIT, WRITE, DONE} state_t;
   function automatic int sat_max(input int w);
      return 2 ** (w - 1) - 1;
   endfunction
endpackage

// File: rtl/pool_addr_gen.sv
// pool_addr_gen: tap/output counters with incremental read and write address bases.
module pool_addr_gen #(
   parameter int ADDR_WIDTH = 5,
   parameter int IN_H       = 4,
   parameter int IN_W       = 4,
   parameter int CH         = 1
) (
   input  logic                  clk,
   input  logic                  resetn,
   input  logic                  i_clear,
   input  logic                  i_tap_adv,
   input  logic                  i_out_adv,
   output logic [ADDR_WIDTH-1:0] o_rd_addr,
   output logic [ADDR_WIDTH-1:0] o_wr_addr,
   output logic [1:0]            o_tap,
   output logic                  o_last_tap,
   output logic                  o_last_out
);
   localparam int AW = ADDR_WIDTH;
   localparam logic [AW-1:0] C_OW_LAST = AW'(IN_W / 2 - 1);
   localparam logic [AW-1:0] C_OH_LAST = AW'(IN_H / 2 - 1);
   localparam logic [AW-1:0] C_CH_LAST = AW'(CH - 1);
   localparam logic [AW-1:0] C_ROW     = AW'(IN_W);
   localparam logic [AW-1:0] C_ROW2    = AW'(2 * IN_W);
   localparam logic [AW-1:0] C_PLANE   = AW'(IN_H * IN_W);
   localparam logic [AW-1:0] C_ONE     = AW'(1);
   localparam logic [AW-1:0] C_TWO     = AW'(2);

   logic [1:0]    r_tap;
   logic [AW-1:0] r_ocol, r_orow, r_c, r_base, r_row_base, r_ch_base, r_wr_addr;

   // r_base is the top-left tap of the current 2x2 window
   assign o_rd_addr  = r_base + (r_tap[1] ? C_ROW : '0) + (r_tap[0] ? C_ONE : '0);
   assign o_wr_addr  = r_wr_addr;
   assign o_tap      = r_tap;
   assign o_last_tap = r_tap == 2'd3;
   assign o_last_out = r_c == C_CH_LAST && r_orow == C_OH_LAST && r_ocol == C_OW_LAST;

   always_ff @(posedge clk) begin
      if (!resetn || i_clear) begin
         r_tap      <= '0;
         r_ocol     <= '0;
         r_orow     <= '0;
         r_c        <= '0;
         r_base     <= '0;
         r_row_base <= '0;
         r_ch_base  <= '0;
         r_wr_addr  <= '0;
      end else begin
         if (i_tap_adv) r_tap <= r_tap + 2'd1;
         if (i_out_adv) begin
            r_wr_addr <= r_wr_addr + C_ONE;
            if (r_ocol != C_OW_LAST) begin
               r_ocol <= r_ocol + C_ONE;
               r_base <= r_base + C_TWO;
            end else if (r_orow != C_OH_LAST) begin
               r_ocol     <= '0;
               r_orow     <= r_orow + C_ONE;
               r_row_base <= r_row_base + C_ROW2;
               r_base     <= r_row_base + C_ROW2;
            end else begin
               r_ocol     <= '0;
               r_orow     <= '0;
               r_c        <= r_c + C_ONE;
               r_ch_base  <= r_ch_base + C_PLANE;
               r_row_base <= r_ch_base + C_PLANE;
               r_base     <= r_ch_base + C_PLANE;
            end
         end
      end
   end
endmodule

// File: rtl/feature_relu_pool.sv
// feature_relu_pool: 2x2/2 max-pool, ReLU, shift and 8-bit saturation from feature RAM to image RAM.
module feature_relu_pool #(
   parameter int WIDTH      = conv_pkg::WIDTH,
   parameter int ADDR_WIDTH = 5,
   parameter int IN_H       = 4,
   parameter int IN_W       = 4,
   parameter int CH         = 1,
   parameter int SHIFT      = 0
) (
   input  logic                  clk,
   input  logic                  resetn,
   input  logic                  start,
   output logic                  busy,
   output logic                  done,
   output logic                  FEATURE_RAM_EN,
   output logic [ADDR_WIDTH-1:0] FEATURE_RAM_ADDRESS,
   input  logic [2*WIDTH-1:0]    FEATURE_RAM_DIN,
   input  logic                  FEATURE_RAM_DATA_VAL,
   output logic                  POOL_RAM_EN,
   output logic                  POOL_RAM_WEN,
   output logic [ADDR_WIDTH-1:0] POOL_RAM_ADDRESS,
   output logic [WIDTH-1:0]      POOL_RAM_DOUT
);
   import conv_pkg::*;

   localparam int DW = 2 * WIDTH;
   localparam logic signed [DW-1:0] C_SAT = DW'(sat_max(WIDTH));

   state_t                 r_state, w_next;
   logic signed [DW-1:0]   r_max, w_relu, w_sh;
   logic                   w_start, w_cap, w_last_tap, w_last_out;
   logic [1:0]             w_tap;

   assign w_start = start && (r_state == IDLE || r_state == DONE);
   assign w_cap   = r_state == WAIT && FEATURE_RAM_DATA_VAL;

   pool_addr_gen #(
      .ADDR_WIDTH(ADDR_WIDTH),
      .IN_H      (IN_H),
      .IN_W      (IN_W),
      .CH        (CH)
   ) u_addr (
      .clk       (clk),
      .resetn    (resetn),
      .i_clear   (w_start),
      .i_tap_adv (w_cap),
      .i_out_adv (r_state == WRITE),
      .o_rd_addr (FEATURE_RAM_ADDRESS),
      .o_wr_addr (POOL_RAM_ADDRESS),
      .o_tap     (w_tap),
      .o_last_tap(w_last_tap),
      .o_last_out(w_last_out)
   );

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         IDLE, DONE: w_next = start ? REQ : r_state;
         REQ:        w_next = WAIT;
         WAIT:       w_next = FEATURE_RAM_DATA_VAL ? (w_last_tap ? WRITE : REQ) : WAIT;
         WRITE:      w_next = w_last_out ? DONE : REQ;
         default:    w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!resetn) r_state <= IDLE;
      else         r_state <= w_next;
   end

   // first tap of a window loads unconditionally; later taps only if strictly greater
   always_ff @(posedge clk) begin
      if (!resetn) r_max <= '0;
      else if (w_cap && (w_tap == 2'd0 || $signed(FEATURE_RAM_DIN) > r_max)) r_max <= $signed(FEATURE_RAM_DIN);
   end

   assign w_relu = r_max[DW-1] ? '0 : r_max;
   assign w_sh   = w_relu >>> SHIFT;

   assign POOL_RAM_DOUT  = w_sh > C_SAT ? C_SAT[WIDTH-1:0] : w_sh[WIDTH-1:0];
   assign busy           = r_state == REQ || r_state == WAIT || r_state == WRITE;
   assign done           = r_state == DONE;
   assign FEATURE_RAM_EN = r_state == REQ;
   assign POOL_RAM_EN    = r_state == WRITE;
   assign POOL_RAM_WEN   = r_state == WRITE;
endmodule

// File: tb/tb_feature_relu_pool.sv
// tb_feature_relu_pool: directed checks of three pool configurations against hand-computed results.
module tb_feature_relu_pool;
   logic        clk = 1'b0;
   logic        resetn;
   logic        start [3];
   logic        busy  [3];
   logic        done  [3];
   logic        en    [3];
   logic [5:0]  ra    [3];
   logic [15:0] din   [3];
   logic        dv    [3];
   logic        pen   [3];
   logic        pwen  [3];
   logic [5:0]  pa_w  [3];
   logic [7:0]  dout  [3];

   logic [15:0] mem [3][64];
   logic [5:0]  wa  [3][16];
   logic [7:0]  wd  [3][16];
   logic [5:0]  pa  [3];
   logic        spur [3];
   int          cnt [3], outst [3], viol [3], enc [3], wn [3];
   int          bad, lat = 10;
   bit          rand_lat = 1'b0;
   int          checks = 0, failures = 0;

   always #5 clk = ~clk;

   feature_relu_pool #(.WIDTH(8), .ADDR_WIDTH(6), .IN_H(4), .IN_W(4), .CH(1), .SHIFT(0)) u0 (
      .clk(clk), .resetn(resetn), .start(start[0]), .busy(busy[0]), .done(done[0]),
      .FEATURE_RAM_EN(en[0]), .FEATURE_RAM_ADDRESS(ra[0]), .FEATURE_RAM_DIN(din[0]),
      .FEATURE_RAM_DATA_VAL(dv[0]), .POOL_RAM_EN(pen[0]), .POOL_RAM_WEN(pwen[0]),
      .POOL_RAM_ADDRESS(pa_w[0]), .POOL_RAM_DOUT(dout[0]));
   feature_relu_pool #(.WIDTH(8), .ADDR_WIDTH(6), .IN_H(4), .IN_W(4), .CH(1), .SHIFT(2)) u1 (
      .clk(clk), .resetn(resetn), .start(start[1]), .busy(busy[1]), .done(done[1]),
      .FEATURE_RAM_EN(en[1]), .FEATURE_RAM_ADDRESS(ra[1]), .FEATURE_RAM_DIN(din[1]),
      .FEATURE_RAM_DATA_VAL(dv[1]), .POOL_RAM_EN(pen[1]), .POOL_RAM_WEN(pwen[1]),
      .POOL_RAM_ADDRESS(pa_w[1]), .POOL_RAM_DOUT(dout[1]));
   feature_relu_pool #(.WIDTH(8), .ADDR_WIDTH(6), .IN_H(5), .IN_W(5), .CH(2), .SHIFT(0)) u2 (
      .clk(clk), .resetn(resetn), .start(start[2]), .busy(busy[2]), .done(done[2]),
      .FEATURE_RAM_EN(en[2]), .FEATURE_RAM_ADDRESS(ra[2]), .FEATURE_RAM_DIN(din[2]),
      .FEATURE_RAM_DATA_VAL(dv[2]), .POOL_RAM_EN(pen[2]), .POOL_RAM_WEN(pwen[2]),
      .POOL_RAM_ADDRESS(pa_w[2]), .POOL_RAM_DOUT(dout[2]));

   // memory models: read data returns L cycles after the EN cycle; writes are logged
   always @(negedge clk) begin
      for (int k = 0; k < 3; k++) begin
         if (!resetn) begin
            cnt[k] = 0; outst[k] = 0; dv[k] = 1'b0; din[k] = '0;
         end else begin
            dv[k] = spur[k];
            if (spur[k]) din[k] = 16'h7fff;
            spur[k] = 1'b0;
            if (cnt[k] > 0) begin
               cnt[k]--;
               if (cnt[k] == 0) begin dv[k] = 1'b1; din[k] = mem[k][pa[k]]; outst[k] = 0; end
            end
            if (en[k]) begin
               enc[k]++;
               if (outst[k] != 0) viol[k]++;
               outst[k] = 1;
               pa[k] = ra[k];
               cnt[k] = rand_lat ? int'($urandom_range(1, 17)) : lat;
               if (k == 2 && ((int'(ra[k]) % 25) % 5 == 4 || (int'(ra[k]) % 25) / 5 == 4)) bad++;
            end
         end
         if (pen[k] && pwen[k]) begin
            if (wn[k] < 16) begin wa[k][wn[k]] = pa_w[k]; wd[k][wn[k]] = dout[k]; end
            wn[k]++;
         end
      end
   end

   task automatic run_pass(input int k, input int poke, output int dc);
      bit poked;
      poked = 1'b0;
      dc = -1;
      wn[k] = 0; enc[k] = 0; viol[k] = 0; bad = 0;
      @(posedge clk); #1 start[k] = 1'b1;
      for (int t = 1; t <= 3000; t++) begin
         @(posedge clk); #1 start[k] = 1'b0;
         @(negedge clk); #1;
         if (done[k]) begin dc = t; break; end
         if (poke != 0 && (t == 20 || (t >= 60 && dv[k] && !poked))) begin
            start[k] = 1'b1;
            if (t >= 60) poked = 1'b1;
         end
      end
   endtask

   task automatic test_reset;
      resetn = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk); #1;
      checks++; if (busy[0] !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0b exp=0", busy[0]); end
      checks++; if (done[0] !== 1'b0) begin failures++; $display("FAIL reset_done got=%0b exp=0", done[0]); end
      checks++; if (en[0] !== 1'b0) begin failures++; $display("FAIL reset_en got=%0b exp=0", en[0]); end
      checks++; if (pen[0] !== 1'b0 || pwen[0] !== 1'b0) begin failures++; $display("FAIL reset_pool_en got=%0b%0b exp=00", pen[0], pwen[0]); end
      checks++; if (pa_w[0] !== 6'd0 || ra[0] !== 6'd0) begin failures++; $display("FAIL reset_addr got=%0d/%0d exp=0/0", pa_w[0], ra[0]); end
      checks++; if (dout[0] !== 8'd0) begin failures++; $display("FAIL reset_dout got=%0d exp=0", dout[0]); end
      @(posedge clk); #1 resetn = 1'b1;
   endtask

   task automatic test_basic;
      int dc;
      int exp_d [4] = '{5, 7, 13, 15};
      for (int a = 0; a < 64; a++) mem[0][a] = 16'(a);
      run_pass(0, 0, dc);
      checks++; if (dc != 181) begin failures++; $display("FAIL basic_done_cycle got=%0d exp=181", dc); end
      checks++; if (wn[0] != 4) begin failures++; $display("FAIL basic_writes got=%0d exp=4", wn[0]); end
      checks++; if (enc[0] != 16) begin failures++; $display("FAIL basic_en_pulses got=%0d exp=16", enc[0]); end
      for (int i = 0; i < 4; i++) begin
         checks++; if (wa[0][i] !== 6'(i) || wd[0][i] !== 8'(exp_d[i])) begin failures++; $display("FAIL basic_write%0d got=%0d@%0d exp=%0d@%0d", i, wd[0][i], wa[0][i], exp_d[i], i); end
      end
   endtask

   task automatic test_relu;
      int dc;
      for (int a = 0; a < 64; a++) mem[1][a] = 16'hFED4;
      run_pass(1, 0, dc);
      checks++; if (dc != 181 || wn[1] != 4) begin failures++; $display("FAIL relu_pass got=%0d/%0d exp=181/4", dc, wn[1]); end
      for (int i = 0; i < 4; i++) begin
         checks++; if (wd[1][i] !== 8'd0) begin failures++; $display("FAIL relu_write%0d got=%0d exp=0", i, wd[1][i]); end
      end
   endtask

   task automatic test_shift;
      int dc;
      int exp_d [4] = '{127, 100, 0, 2};
      int taps [16] = '{1000, -5, 400, 0, 3, 2, 0, 0, -1, -2, 7, 8, -3, -4, 9, 10};
      for (int a = 0; a < 16; a++) mem[1][a] = 16'(taps[a]);
      run_pass(1, 0, dc);
      checks++; if (dc != 181 || wn[1] != 4) begin failures++; $display("FAIL shift_pass got=%0d/%0d exp=181/4", dc, wn[1]); end
      for (int i = 0; i < 4; i++) begin
         checks++; if (wa[1][i] !== 6'(i) || wd[1][i] !== 8'(exp_d[i])) begin failures++; $display("FAIL shift_write%0d got=%0d@%0d exp=%0d@%0d", i, wd[1][i], wa[1][i], exp_d[i], i); end
      end
   endtask

   task automatic test_multi;
      int dc;
      int exp_d [8] = '{6, 8, 16, 18, 31, 33, 41, 43};
      for (int a = 0; a < 64; a++) mem[2][a] = 16'(a);
      run_pass(2, 0, dc);
      checks++; if (dc != 361) begin failures++; $display("FAIL multi_done_cycle got=%0d exp=361", dc); end
      checks++; if (wn[2] != 8 || enc[2] != 32) begin failures++; $display("FAIL multi_counts got=%0d/%0d exp=8/32", wn[2], enc[2]); end
      checks++; if (bad != 0) begin failures++; $display("FAIL multi_odd_edge_reads got=%0d exp=0", bad); end
      for (int i = 0; i < 8; i++) begin
         checks++; if (wa[2][i] !== 6'(i) || wd[2][i] !== 8'(exp_d[i])) begin failures++; $display("FAIL multi_write%0d got=%0d@%0d exp=%0d@%0d", i, wd[2][i], wa[2][i], exp_d[i], i); end
      end
   endtask

   task automatic test_random_latency;
      int dc;
      int exp_d [4] = '{5, 7, 13, 15};
      rand_lat = 1'b1;
      run_pass(0, 0, dc);
      rand_lat = 1'b0;
      checks++; if (dc < 0 || wn[0] != 4 || enc[0] != 16) begin failures++; $display("FAIL randlat_pass got=%0d/%0d/%0d exp=done/4/16", dc, wn[0], enc[0]); end
      checks++; if (viol[0] != 0) begin failures++; $display("FAIL randlat_outstanding got=%0d exp=0", viol[0]); end
      for (int i = 0; i < 4; i++) begin
         checks++; if (wa[0][i] !== 6'(i) || wd[0][i] !== 8'(exp_d[i])) begin failures++; $display("FAIL randlat_write%0d got=%0d@%0d exp=%0d@%0d", i, wd[0][i], wa[0][i], exp_d[i], i); end
      end
   endtask

   task automatic test_spurious_done;
      int n0 = wn[0];
      int e0 = enc[0];
      repeat (3) begin @(posedge clk); #1 spur[0] = 1'b1; end
      repeat (3) @(posedge clk);
      @(negedge clk); #1;
      checks++; if (done[0] !== 1'b1 || busy[0] !== 1'b0) begin failures++; $display("FAIL spur_done_state got=%0b%0b exp=10", done[0], busy[0]); end
      checks++; if (wn[0] != n0 || enc[0] != e0) begin failures++; $display("FAIL spur_done_activity got=%0d/%0d exp=%0d/%0d", wn[0], enc[0], n0, e0); end
   endtask

   task automatic test_start_busy;
      int dc;
      int exp_d [4] = '{5, 7, 13, 15};
      run_pass(0, 1, dc);
      checks++; if (dc != 181 || wn[0] != 4 || enc[0] != 16) begin failures++; $display("FAIL busy_start_pass got=%0d/%0d/%0d exp=181/4/16", dc, wn[0], enc[0]); end
      for (int i = 0; i < 4; i++) begin
         checks++; if (wd[0][i] !== 8'(exp_d[i])) begin failures++; $display("FAIL busy_start_write%0d got=%0d exp=%0d", i, wd[0][i], exp_d[i]); end
      end
   endtask

   task automatic test_reset_mid;
      int dc;
      bit hit = 1'b0;
      int exp_d [4] = '{5, 7, 13, 15};
      wn[0] = 0;
      @(posedge clk); #1 start[0] = 1'b1;
      @(posedge clk); #1 start[0] = 1'b0;
      for (int t = 0; t < 500; t++) begin
         @(negedge clk);
         if (wn[0] == 2) begin hit = 1'b1; break; end
      end
      checks++; if (!hit) begin failures++; $display("FAIL midreset_reach_out2 got=%0d exp=2", wn[0]); end
      @(posedge clk);
      @(posedge clk); #1 resetn = 1'b0;
      @(posedge clk); #1 resetn = 1'b1;
      @(negedge clk); #1;
      checks++; if (busy[0] !== 1'b0 || done[0] !== 1'b0 || en[0] !== 1'b0 || pen[0] !== 1'b0) begin failures++; $display("FAIL midreset_ctrl got=%0b%0b%0b%0b exp=0000", busy[0], done[0], en[0], pen[0]); end
      checks++; if (pa_w[0] !== 6'd0 || dout[0] !== 8'd0) begin failures++; $display("FAIL midreset_data got=%0d/%0d exp=0/0", pa_w[0], dout[0]); end
      @(posedge clk); #1 spur[0] = 1'b1;
      repeat (30) @(posedge clk);
      @(negedge clk); #1;
      checks++; if (wn[0] != 2 || busy[0] !== 1'b0 || done[0] !== 1'b0) begin failures++; $display("FAIL midreset_idle got=%0d/%0b%0b exp=2/00", wn[0], busy[0], done[0]); end
      run_pass(0, 0, dc);
      checks++; if (dc != 181 || wn[0] != 4) begin failures++; $display("FAIL midreset_rerun got=%0d/%0d exp=181/4", dc, wn[0]); end
      for (int i = 0; i < 4; i++) begin
         checks++; if (wa[0][i] !== 6'(i) || wd[0][i] !== 8'(exp_d[i])) begin failures++; $display("FAIL midreset_write%0d got=%0d@%0d exp=%0d@%0d", i, wd[0][i], wa[0][i], exp_d[i], i); end
      end
   endtask

   initial begin
      resetn = 1'b0;
      for (int k = 0; k < 3; k++) begin
         start[k] = 1'b0; spur[k] = 1'b0; cnt[k] = 0; outst[k] = 0;
         viol[k] = 0; enc[k] = 0; wn[k] = 0;
         for (int a = 0; a < 64; a++) mem[k][a] = '0;
      end
      bad = 0;
      test_reset;
      test_basic;
      test_relu;
      test_shift;
      test_multi;
      test_random_latency;
      test_spurious_done;
      test_start_busy;
      test_reset_mid;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
